cache_page_controller: RTL

- Cache engine behind the cache management register block.
- Responds to the busMemory* request interface.
- Keeps per-page tags and valid/dirty state, serves hits from the on-chip SRAM, and moves whole pages to and from external memory over a word handshake on a miss or a manual page change.
- Drives the status inputs of the management block: initialised, loading, saving, busy, and per-page set/load/flush.

---
 rtl/cache_page_controller.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_page_controller.sv
// Page-based cache engine: per-slot tags with valid/dirty state, hits served from
// on-chip SRAM, whole-page flush/load to external memory over a word handshake.
module cache_page_controller #(
   parameter int ADDRESS_SIZE            = 24,
   parameter int SRAM_ADDRESS_SIZE       = 9,
   parameter int PAGE_INDEX_ADDRESS_SIZE = 3
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            cacheEnable,
   input  logic                                            automaticPaging,
   input  logic                                            manualPageAddressSet,
   input  logic [ADDRESS_SIZE-SRAM_ADDRESS_SIZE-3:0]       manualPageAddress,
   input  logic                                            busMemoryEnable,
   input  logic                                            busMemoryWriteEnable,
   input  logic [ADDRESS_SIZE-1:0]                         busMemoryAddress,
   input  logic [3:0]                                      busMemoryByteSelect,
   input  logic [31:0]                                     busMemoryDataWrite,
   output logic [31:0]                                     busMemoryDataRead,
   output logic                                            busMemoryBusy,
   output logic                                            sram_en,
   output logic                                            sram_we,
   output logic [SRAM_ADDRESS_SIZE-1:0]                    sram_address,
   output logic [3:0]                                      sram_byteSelect,
   output logic [31:0]                                     sram_dataWrite,
   input  logic [31:0]                                     sram_dataRead,
   output logic                                            ext_request,
   output logic                                            ext_we,
   output logic [ADDRESS_SIZE-1:0]                         ext_address,
   output logic [31:0]                                     ext_dataWrite,
   input  logic [31:0]                                     ext_dataRead,
   input  logic                                            ext_ack,
   output logic                                            cacheInitialised,
   output logic                                            cacheRequestData,
   output logic                                            cacheStoreData,
   output logic                                            cacheBusy,
   output logic [(2**PAGE_INDEX_ADDRESS_SIZE)-1:0]         pageAddressSet,
   output logic [(2**PAGE_INDEX_ADDRESS_SIZE)-1:0]         pageRequestLoad,
   output logic [(2**PAGE_INDEX_ADDRESS_SIZE)-1:0]         pageRequestFlush
);

   localparam int PI  = PAGE_INDEX_ADDRESS_SIZE;
   localparam int PC  = 2**PAGE_INDEX_ADDRESS_SIZE;
   localparam int PDS = SRAM_ADDRESS_SIZE - PAGE_INDEX_ADDRESS_SIZE;
   localparam int PNS = ADDRESS_SIZE - PDS - 2;
   localparam int MPS = PNS - PI;

   // Handshakes: the bus master holds busMemoryEnable and its address/data until it
   // samples busMemoryBusy=0 at a clock edge, which completes the access (read data is
   // valid in that cycle). ext_request with its address/data is held until ext_ack is
   // sampled high, then drops on the following cycle.
   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_READ,
      S_SCAN,
      S_FLUSH_READ,
      S_FLUSH_CAPTURE,
      S_FLUSH_WAIT,
      S_LOAD_REQUEST,
      S_LOAD_WAIT
   } state_t;

   state_t             state;
   logic [PNS-1:0]     tags [PC];
   logic [PC-1:0]      valid;
   logic [PC-1:0]      dirty;
   logic [PC-1:0]      load_pending;
   logic [PC-1:0]      flush_pending;
   logic [MPS-1:0]     window;
   logic [PI-1:0]      init_slot;
   logic [PI-1:0]      xfer_slot;
   logic [PDS-1:0]     word;
   logic [PNS-1:0]     load_page;
   logic               initialised;

   logic [PDS-1:0]     bus_word;
   logic [PI-1:0]      bus_slot;
   logic [PNS-1:0]     bus_page;
   logic               hit;
   logic               cache_busy;
   logic               take_set;
   logic               serve;
   logic [PI-1:0]      scan_slot;
   logic               scan_found;

   assign bus_word   = busMemoryAddress[PDS+1:2];
   assign bus_slot   = busMemoryAddress[SRAM_ADDRESS_SIZE+1:PDS+2];
   assign bus_page   = automaticPaging ? busMemoryAddress[ADDRESS_SIZE-1:PDS+2]
                                       : {window, bus_slot};
   assign hit        = valid[bus_slot] && (tags[bus_slot] == bus_page);
   assign cache_busy = (state != S_IDLE) || (|load_pending) || (|flush_pending);
   // A manual window change takes priority over a bus access in the same cycle.
   assign take_set   = (state == S_IDLE) && manualPageAddressSet && !cache_busy;
   assign serve      = (state == S_IDLE) && busMemoryEnable && cacheEnable && !take_set;

   always_comb begin
      scan_found = 1'b0;
      scan_slot  = '0;
      for (int i = PC - 1; i >= 0; i--) begin
         if (load_pending[i]) begin
            scan_found = 1'b1;
            scan_slot  = PI'(i);
         end
      end
   end

   always_comb begin
      busMemoryBusy = 1'b0;
      case (state)
         S_IDLE:  busMemoryBusy = busMemoryEnable && cacheEnable &&
                                  (take_set || !hit || !busMemoryWriteEnable);
         S_READ:  busMemoryBusy = 1'b0;
         default: busMemoryBusy = busMemoryEnable;
      endcase
   end

   always_comb begin
      sram_en         = 1'b0;
      sram_we         = 1'b0;
      sram_address    = '0;
      sram_byteSelect = '0;
      sram_dataWrite  = '0;
      if (serve && hit) begin
         sram_en         = 1'b1;
         sram_we         = busMemoryWriteEnable;
         sram_address    = {bus_slot, bus_word};
         sram_byteSelect = busMemoryByteSelect;
         sram_dataWrite  = busMemoryDataWrite;
      end else if (state == S_FLUSH_READ) begin
         sram_en         = 1'b1;
         sram_address    = {xfer_slot, word};
         sram_byteSelect = 4'hF;
      end else if ((state == S_LOAD_WAIT) && ext_ack) begin
         sram_en         = 1'b1;
         sram_we         = 1'b1;
         sram_address    = {xfer_slot, word};
         sram_byteSelect = 4'hF;
         sram_dataWrite  = ext_dataRead;
      end
   end

   assign busMemoryDataRead = (state == S_READ) ? sram_dataRead : '1;
   assign cacheInitialised  = initialised;
   assign cacheRequestData  = (state == S_LOAD_REQUEST) || (state == S_LOAD_WAIT);
   assign cacheStoreData    = (state == S_FLUSH_READ) || (state == S_FLUSH_CAPTURE) ||
                              (state == S_FLUSH_WAIT);
   assign cacheBusy         = cache_busy;
   assign pageAddressSet    = valid;
   assign pageRequestLoad   = load_pending;
   assign pageRequestFlush  = flush_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_INIT;
         valid         <= '0;
         dirty         <= '0;
         load_pending  <= '0;
         flush_pending <= '0;
         window        <= '0;
         init_slot     <= '0;
         xfer_slot     <= '0;
         word          <= '0;
         load_page     <= '0;
         initialised   <= 1'b0;
         ext_request   <= 1'b0;
         ext_we        <= 1'b0;
         ext_address   <= '0;
         ext_dataWrite <= '0;
         for (int i = 0; i < PC; i++) tags[i] <= '0;
      end else begin
         case (state)
            S_INIT: begin
               valid[init_slot] <= 1'b0;
               dirty[init_slot] <= 1'b0;
               init_slot        <= init_slot + 1'b1;
               if (init_slot == PI'(PC - 1)) begin
                  state       <= S_IDLE;
                  initialised <= 1'b1;
               end
            end
            S_IDLE: begin
               if (take_set) begin
                  window        <= manualPageAddress;
                  load_pending  <= '1;
                  flush_pending <= dirty;
                  state         <= S_SCAN;
               end else if (serve) begin
                  if (hit) begin
                     if (busMemoryWriteEnable) dirty[bus_slot] <= 1'b1;
                     else                      state <= S_READ;
                  end else begin
                     load_pending[bus_slot]  <= 1'b1;
                     flush_pending[bus_slot] <= dirty[bus_slot];
                     xfer_slot               <= bus_slot;
                     load_page               <= bus_page;
                     word                    <= '0;
                     state <= dirty[bus_slot] ? S_FLUSH_READ : S_LOAD_REQUEST;
                  end
               end
            end
            S_READ: state <= S_IDLE;
            // Services pending slots lowest-first; an auto miss also returns here.
            S_SCAN: begin
               if (scan_found) begin
                  xfer_slot <= scan_slot;
                  load_page <= {window, scan_slot};
                  word      <= '0;
                  state     <= flush_pending[scan_slot] ? S_FLUSH_READ : S_LOAD_REQUEST;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_FLUSH_READ: state <= S_FLUSH_CAPTURE;
            S_FLUSH_CAPTURE: begin
               ext_request   <= 1'b1;
               ext_we        <= 1'b1;
               ext_address   <= {tags[xfer_slot], word, 2'b00};
               ext_dataWrite <= sram_dataRead;
               state         <= S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
               if (ext_ack) begin
                  ext_request <= 1'b0;
                  word        <= word + 1'b1;
                  if (word == '1) begin
                     dirty[xfer_slot]         <= 1'b0;
                     flush_pending[xfer_slot] <= 1'b0;
                     state                    <= S_LOAD_REQUEST;
                  end else begin
                     state <= S_FLUSH_READ;
                  end
               end
            end
            S_LOAD_REQUEST: begin
               ext_request <= 1'b1;
               ext_we      <= 1'b0;
               ext_address <= {load_page, word, 2'b00};
               state       <= S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
               if (ext_ack) begin
                  ext_request <= 1'b0;
                  word        <= word + 1'b1;
                  if (word == '1) begin
                     tags[xfer_slot]         <= load_page;
                     valid[xfer_slot]        <= 1'b1;
                     load_pending[xfer_slot] <= 1'b0;
                     state                   <= S_SCAN;
                  end else begin
                     state <= S_LOAD_REQUEST;
                  end
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule
